// File: rtl/ltpi_pkg.sv
// Shared types for the LTPI PLL reconfiguration sequencer.
package ltpi_pkg;

    localparam int PLL_CFG_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        WAIT_LOCK,
        FAIL,
        SUCCESS
    } pll_reconfig_state_t;

endpackage

// File: rtl/pll_lock_filter.sv
// Two-flop synchronizer for the asynchronous PLL lock, followed by a
// qualifier that requires LOCK_STABLE consecutive high cycles.
module pll_lock_filter #(
    parameter int LOCK_STABLE = 16
) (
    input  logic mgmt_clk,
    input  logic reset_n,
    input  logic pll_locked,
    input  logic clear,
    output logic lock_ok
);

    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);

    logic          sync1_q;
    logic          sync2_q;
    logic [SW-1:0] stable_q;
    logic [SW-1:0] stable_d;

    always_ff @(posedge mgmt_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= '0;
        end else begin
            sync1_q  <= pll_locked;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
        end
    end

    // Any low sample restarts qualification; saturate once qualified.
    always_comb begin
        stable_d = stable_q;
        if (clear || !sync2_q) begin
            stable_d = '0;
        end else if (stable_q != STABLE_MAX) begin
            stable_d = stable_q + 1'b1;
        end
    end

    assign lock_ok = (stable_q == STABLE_MAX);

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Sequencer driving the m10_pll_top reconfiguration port for link training.
// Build option: define PLL_RECONFIG_CTRL_RETRY_EN to retry failed attempts.
module pll_reconfig_ctrl
    import ltpi_pkg::*;
#(
    parameter int DONE_TIMEOUT = 1024,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 16,
    parameter int MAX_RETRY    = 2
) (
    input  logic                 mgmt_clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  logic [PLL_CFG_W-1:0] req_config,
    output logic                 req_ready,
    output logic [PLL_CFG_W-1:0] mgmt_clk_configuration,
    output logic                 mgmt_clk_reconfig,
    input  logic                 mgmt_clk_configuration_done,
    input  logic                 pll_locked,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [PLL_CFG_W-1:0] current_config,
    output logic [1:0]           retry_cnt
);

`ifdef PLL_RECONFIG_CTRL_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int TMAX  = (DONE_TIMEOUT > LOCK_TIMEOUT) ? DONE_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNT_W = $clog2(TMAX + 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    pll_reconfig_state_t  state_q, state_d;
    logic [PLL_CFG_W-1:0] cfg_q, cfg_d;
    logic [PLL_CFG_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]     tmo_q, tmo_d;
    logic [1:0]           retry_q, retry_d;
    logic                 reconfig_q, reconfig_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 lock_ok;
    logic                 retry_avail;

    pll_lock_filter #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_filter (
        .mgmt_clk   (mgmt_clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .clear      (state_q == ISSUE),
        .lock_ok    (lock_ok)
    );

    assign retry_avail = RETRY_EN && (retry_q < RETRY_MAX);

    always_ff @(posedge mgmt_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            cur_q      <= '0;
            tmo_q      <= '0;
            retry_q    <= '0;
            reconfig_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            cur_q      <= cur_d;
            tmo_q      <= tmo_d;
            retry_q    <= retry_d;
            reconfig_q <= reconfig_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        cur_d      = cur_q;
        tmo_d      = tmo_q;
        retry_d    = retry_q;
        reconfig_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cfg_d   = req_config;
                    error_d = 1'b0;
                    retry_d = '0;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                reconfig_d = 1'b1;
                tmo_d      = '0;
                state_d    = WAIT_DONE;
            end
            // Done on the timeout cycle is still a success.
            WAIT_DONE: begin
                if (mgmt_clk_configuration_done) begin
                    tmo_d   = '0;
                    state_d = WAIT_LOCK;
                end else if (tmo_q == DONE_LAST) begin
                    state_d = FAIL;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_ok) begin
                    state_d = SUCCESS;
                end else if (tmo_q == LOCK_LAST) begin
                    state_d = FAIL;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            SUCCESS: begin
                done_d  = 1'b1;
                cur_d   = cfg_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            FAIL: begin
                if (retry_avail) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ISSUE;
                end else begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready              = (state_q == IDLE);
    assign mgmt_clk_configuration = cfg_q;
    assign mgmt_clk_reconfig      = reconfig_q;
    assign busy                   = busy_q;
    assign done                   = done_q;
    assign error                  = error_q;
    assign current_config         = cur_q;
    assign retry_cnt              = RETRY_EN ? retry_q : 2'b00;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scenario bench for pll_reconfig_ctrl with a queued expectation per request.
module tb_pll_reconfig_ctrl;

    localparam int DT = 1024;
    localparam int LT = 4096;
    localparam int LS = 16;
    localparam int MR = 2;
`ifdef PLL_RECONFIG_CTRL_RETRY_EN
    localparam int EXP_RTY = MR;
`else
    localparam int EXP_RTY = 0;
`endif

    logic       mgmt_clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic [2:0] req_config;
    logic       req_ready;
    logic [2:0] mgmt_clk_configuration;
    logic       mgmt_clk_reconfig;
    logic       mgmt_clk_configuration_done;
    logic       pll_locked;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] current_config;
    logic [1:0] retry_cnt;

    typedef struct {
        logic       err;
        logic [2:0] cfg;
        logic [1:0] rty;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // PLL model, and task-side overrides
    logic task_done = 1'b0;
    logic task_lock = 1'b0;
    logic model_done = 1'b0;
    logic model_lock = 1'b0;
    bit   model_on = 1'b0;
    bit   tog_on = 1'b0;
    int   dly = 5;
    int   dcnt = -1;
    int   tcnt = 0;

    // Pulse monitor
    int   pulses = 0;
    int   cyc = 0;
    int   pulse_t[$];
    logic rc_prev = 1'b0;

    assign mgmt_clk_configuration_done = task_done | model_done;
    assign pll_locked = tog_on ? model_lock : task_lock;

    always #5 mgmt_clk = ~mgmt_clk;

    pll_reconfig_ctrl #(
        .DONE_TIMEOUT (DT),
        .LOCK_TIMEOUT (LT),
        .LOCK_STABLE  (LS),
        .MAX_RETRY    (MR)
    ) dut (
        .mgmt_clk                    (mgmt_clk),
        .reset_n                     (reset_n),
        .req_valid                   (req_valid),
        .req_config                  (req_config),
        .req_ready                   (req_ready),
        .mgmt_clk_configuration      (mgmt_clk_configuration),
        .mgmt_clk_reconfig           (mgmt_clk_reconfig),
        .mgmt_clk_configuration_done (mgmt_clk_configuration_done),
        .pll_locked                  (pll_locked),
        .busy                        (busy),
        .done                        (done),
        .error                       (error),
        .current_config              (current_config),
        .retry_cnt                   (retry_cnt)
    );

    always @(negedge mgmt_clk) begin
        cyc++;
        if (mgmt_clk_reconfig === 1'b1 && rc_prev !== 1'b1) begin
            pulses++;
            pulse_t.push_back(cyc);
        end
        rc_prev = mgmt_clk_reconfig;
    end

    always @(negedge mgmt_clk) begin
        model_done = 1'b0;
        if (model_on) begin
            if (dcnt == 0) begin
                model_done = 1'b1;
                dcnt = -1;
            end else if (dcnt > 0) begin
                dcnt--;
            end
            if (mgmt_clk_reconfig === 1'b1) dcnt = dly;
        end else begin
            dcnt = -1;
        end
        tcnt = (tcnt + 1) % 10;
        model_lock = (tcnt != 0);
    end

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge mgmt_clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_req(input logic [2:0] c);
        @(negedge mgmt_clk);
        req_config = c;
        req_valid  = 1'b1;
        @(negedge mgmt_clk);
        req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_config = 3'h0;
        #23;
        got = {mgmt_clk_configuration, mgmt_clk_reconfig, busy, done,
               error, current_config, retry_cnt, req_ready};
        n_cmp++;
        if (got !== 14'b000_0_0_0_0_000_00_1) begin
            n_bad++;
            $display("FAIL reset_held: got %b want %b", got, 14'b000_0_0_0_0_000_00_1);
        end
        @(negedge mgmt_clk);
        reset_n = 1'b1;
        repeat (3) @(negedge mgmt_clk);
        got = {mgmt_clk_configuration, mgmt_clk_reconfig, busy, done,
               error, current_config, retry_cnt, req_ready};
        n_cmp++;
        if (got !== 14'b000_0_0_0_0_000_00_1) begin
            n_bad++;
            $display("FAIL reset_release: got %b want %b", got, 14'b000_0_0_0_0_000_00_1);
        end
    endtask

    task automatic test_basic();
        int   p0;
        int   k;
        bit   ok;
        exp_t e;
        model_on = 1'b0;
        task_lock = 1'b0;
        p0 = pulses;
        sb.push_back('{err: 1'b0, cfg: 3'h5, rty: 2'd0});
        start_req(3'h5);
        n_cmp++;
        if ({busy, req_ready, mgmt_clk_configuration} !== {1'b1, 1'b0, 3'h5}) begin
            n_bad++;
            $display("FAIL accept: busy/ready/cfg got %b%b%h want 105",
                     busy, req_ready, mgmt_clk_configuration);
        end
        k = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge mgmt_clk);
            k++;
            if (mgmt_clk_reconfig === 1'b1) break;
        end
        n_cmp++;
        if (k != 1 || mgmt_clk_reconfig !== 1'b1) begin
            n_bad++;
            $display("FAIL pulse_latency: got %0d cycles want 1", k);
        end
        @(negedge mgmt_clk);
        n_cmp++;
        if (mgmt_clk_reconfig !== 1'b0) begin
            n_bad++;
            $display("FAIL pulse_width: reconfig still %b want 0", mgmt_clk_reconfig);
        end
        repeat (9) @(negedge mgmt_clk);
        task_done = 1'b1;
        @(negedge mgmt_clk);
        task_done = 1'b0;
        task_lock = 1'b1;
        k = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge mgmt_clk);
            k++;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok || k != LS + 4) begin
            n_bad++;
            $display("FAIL lock_latency: got %0d cycles (seen %0b) want %0d", k, ok, LS + 4);
        end
        if (ok) begin
            e = sb.pop_front();
            n_cmp++;
            if ({error, current_config, retry_cnt} !== {e.err, e.cfg, e.rty}) begin
                n_bad++;
                $display("FAIL basic_result: err/cfg/rty got %b/%h/%0d want %b/%h/%0d",
                         error, current_config, retry_cnt, e.err, e.cfg, e.rty);
            end
        end
        n_cmp++;
        if (pulses - p0 != 1) begin
            n_bad++;
            $display("FAIL basic_pulses: got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_done_timeout();
        int   p0;
        int   t0;
        int   gap;
        bit   ok;
        exp_t e;
        model_on = 1'b0;
        task_lock = 1'b0;
        p0 = pulses;
        t0 = pulse_t.size();
        sb.push_back('{err: 1'b1, cfg: 3'h5, rty: 2'(EXP_RTY)});
        start_req(3'h3);
        wait_done((MR + 1) * (DT + 20), ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL done_timeout_wait: no done pulse, got 0 want 1");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({error, current_config, retry_cnt} !== {e.err, e.cfg, e.rty}) begin
                n_bad++;
                $display("FAIL done_timeout_result: err/cfg/rty got %b/%h/%0d want %b/%h/%0d",
                         error, current_config, retry_cnt, e.err, e.cfg, e.rty);
            end
        end
        n_cmp++;
        if (pulses - p0 != 1 + EXP_RTY) begin
            n_bad++;
            $display("FAIL done_timeout_pulses: got %0d want %0d", pulses - p0, 1 + EXP_RTY);
        end
        for (int i = t0 + 1; i < pulse_t.size(); i++) begin
            gap = pulse_t[i] - pulse_t[i-1];
            n_cmp++;
            if (gap < DT || gap > DT + 4) begin
                n_bad++;
                $display("FAIL retry_spacing: got %0d want %0d..%0d", gap, DT, DT + 4);
            end
        end
        repeat (3) @(negedge mgmt_clk);
        n_cmp++;
        if ({error, mgmt_clk_configuration, busy} !== {1'b1, 3'h3, 1'b0}) begin
            n_bad++;
            $display("FAIL fail_hold: err/cfg/busy got %b/%h/%b want 1/3/0",
                     error, mgmt_clk_configuration, busy);
        end
    endtask

    task automatic test_lock_toggle();
        int   p0;
        bit   ok;
        exp_t e;
        dly = 5;
        model_on = 1'b1;
        tog_on = 1'b1;
        p0 = pulses;
        sb.push_back('{err: 1'b1, cfg: 3'h5, rty: 2'(EXP_RTY)});
        start_req(3'h6);
        wait_done((MR + 1) * (LT + 40), ok);
        model_on = 1'b0;
        tog_on = 1'b0;
        task_lock = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL lock_toggle_wait: no done pulse, got 0 want 1");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({error, current_config, retry_cnt} !== {e.err, e.cfg, e.rty}) begin
                n_bad++;
                $display("FAIL lock_toggle_result: err/cfg/rty got %b/%h/%0d want %b/%h/%0d",
                         error, current_config, retry_cnt, e.err, e.cfg, e.rty);
            end
        end
        n_cmp++;
        if (pulses - p0 != 1 + EXP_RTY) begin
            n_bad++;
            $display("FAIL lock_toggle_pulses: got %0d want %0d", pulses - p0, 1 + EXP_RTY);
        end
    endtask

    task automatic test_back_to_back();
        int   p0;
        int   ndone;
        exp_t e;
        dly = 3;
        model_on = 1'b1;
        task_lock = 1'b1;
        p0 = pulses;
        ndone = 0;
        sb.push_back('{err: 1'b0, cfg: 3'h1, rty: 2'd0});
        sb.push_back('{err: 1'b0, cfg: 3'h2, rty: 2'd0});
        @(negedge mgmt_clk);
        req_config = 3'h1;
        req_valid = 1'b1;
        @(negedge mgmt_clk);
        req_config = 3'h2;
        repeat (4) @(negedge mgmt_clk);
        n_cmp++;
        if ({busy, req_ready, mgmt_clk_configuration} !== {1'b1, 1'b0, 3'h1}) begin
            n_bad++;
            $display("FAIL held_request: busy/ready/cfg got %b%b%h want 101",
                     busy, req_ready, mgmt_clk_configuration);
        end
        for (int i = 0; i < 400 && ndone < 2; i++) begin
            @(negedge mgmt_clk);
            if (done === 1'b1) begin
                ndone++;
                e = sb.pop_front();
                n_cmp++;
                if ({error, current_config, retry_cnt} !== {e.err, e.cfg, e.rty}) begin
                    n_bad++;
                    $display("FAIL b2b_result%0d: err/cfg/rty got %b/%h/%0d want %b/%h/%0d",
                             ndone, error, current_config, retry_cnt, e.err, e.cfg, e.rty);
                end
            end else if (ndone == 1 && busy === 1'b1 && req_valid) begin
                req_valid = 1'b0;
                n_cmp++;
                if (mgmt_clk_configuration !== 3'h2) begin
                    n_bad++;
                    $display("FAIL second_accept: cfg got %h want 2", mgmt_clk_configuration);
                end
            end
        end
        req_valid = 1'b0;
        model_on = 1'b0;
        n_cmp++;
        if (ndone != 2 || pulses - p0 != 2) begin
            n_bad++;
            $display("FAIL b2b_count: dones/pulses got %0d/%0d want 2/2", ndone, pulses - p0);
        end
    endtask

    task automatic test_done_on_timeout();
        bit   ok;
        bit   seen;
        exp_t e;
        model_on = 1'b0;
        task_lock = 1'b1;
        seen = 1'b0;
        sb.push_back('{err: 1'b0, cfg: 3'h7, rty: 2'd0});
        start_req(3'h7);
        for (int i = 0; i < 5; i++) begin
            @(negedge mgmt_clk);
            if (mgmt_clk_reconfig === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL edge_pulse: reconfig got 0 want 1");
        end
        repeat (DT - 1) @(negedge mgmt_clk);
        task_done = 1'b1;
        @(negedge mgmt_clk);
        task_done = 1'b0;
        wait_done(100, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL edge_wait: no done pulse, got 0 want 1");
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({error, current_config, retry_cnt} !== {e.err, e.cfg, e.rty}) begin
                n_bad++;
                $display("FAIL edge_result: err/cfg/rty got %b/%h/%0d want %b/%h/%0d",
                         error, current_config, retry_cnt, e.err, e.cfg, e.rty);
            end
        end
    endtask

    task automatic test_reset_mid();
        int          p0;
        logic [13:0] got;
        dly = 4;
        model_on = 1'b1;
        task_lock = 1'b0;
        start_req(3'h4);
        repeat (40) @(negedge mgmt_clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        reset_n = 1'b0;
        #1;
        got = {mgmt_clk_configuration, mgmt_clk_reconfig, busy, done,
               error, current_config, retry_cnt, req_ready};
        n_cmp++;
        if (got !== 14'b000_0_0_0_0_000_00_1) begin
            n_bad++;
            $display("FAIL mid_reset: got %b want %b", got, 14'b000_0_0_0_0_000_00_1);
        end
        @(negedge mgmt_clk);
        model_on = 1'b0;
        reset_n = 1'b1;
        p0 = pulses;
        repeat (200) @(negedge mgmt_clk);
        n_cmp++;
        if (pulses != p0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset: pulses/busy got %0d/%b want 0/0", pulses - p0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_done_timeout();
        test_lock_toggle();
        test_back_to_back();
        test_done_on_timeout();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Sequencer that drives the `m10_pll_top` reconfiguration port on behalf of LTPI link training. It accepts a requested clock configuration index and issues exactly one `mgmt_clk_reconfig` pulse, then waits for `mgmt_clk_configuration_done`. It then qualifies the PLL `locked` output as stable and reports success or failure back to the requester. It sits directly upstream of `m10_pll_top` in the `mgmt_clk` domain and replaces the free-running tester stimulus in the product build.

## Interface
Parameters:
- `DONE_TIMEOUT`, 1024: max `mgmt_clk` cycles to wait for `mgmt_clk_configuration_done` after the reconfig pulse.
- `LOCK_TIMEOUT`, 4096: max cycles to wait in WAIT_LOCK for a qualified lock.
- `LOCK_STABLE`, 16: consecutive cycles the synchronized lock must be high to qualify.
- `MAX_RETRY`, 2: additional attempts after the first failure. Used only with retry compiled in.

Ports:
- `mgmt_clk`  in  1  block clock (PLL management clock)
- `reset_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  reconfiguration request
- `req_config`  in  3  requested configuration index
- `req_ready`  out  1  high only in IDLE; request accepted on `req_valid && req_ready`
- `mgmt_clk_configuration`  out  3  configuration index to PLL, registered
- `mgmt_clk_reconfig`  out  1  single-cycle reconfiguration strobe, registered
- `mgmt_clk_configuration_done`  in  1  PLL reconfiguration complete, synchronous to `mgmt_clk`
- `pll_locked`  in  1  PLL lock, asynchronous; synchronized internally
- `busy`  out  1  high from acceptance until return to IDLE
- `done`  out  1  one-cycle completion pulse, on success or final failure
- `error`  out  1  sticky failure flag; cleared on the next accepted request
- `current_config`  out  3  last successfully applied configuration
- `retry_cnt`  out  2  attempts made beyond the first in the current request

## Operation
- States are IDLE, ISSUE, WAIT_DONE, WAIT_LOCK, FAIL and SUCCESS.
- **IDLE:** on acceptance, latch `req_config` into `mgmt_clk_configuration`, clear `error` and `retry_cnt`, then go to ISSUE.
- **ISSUE:** assert `mgmt_clk_reconfig` for exactly one cycle, clear the timeout counter, then go to WAIT_DONE.
- **WAIT_DONE:**
  - `mgmt_clk_configuration_done` high → go to WAIT_LOCK.
  - Counter reaches `DONE_TIMEOUT-1` → go to FAIL.
  - If done arrives on the timeout cycle, done wins.
- **WAIT_LOCK:**
  - The stable counter increments while the synchronized lock is high and clears on any low cycle.
  - Stable counter reaches `LOCK_STABLE` → go to SUCCESS.
  - Timeout counter reaches `LOCK_TIMEOUT-1` → go to FAIL.
  - If both happen in the same cycle, success wins.
- **SUCCESS:** pulse `done`, set `current_config` to `mgmt_clk_configuration`, go to IDLE.
- **FAIL:**
  - Retry available → increment `retry_cnt` and go to ISSUE.
  - Otherwise → set `error`, pulse `done`, go to IDLE.
- `mgmt_clk_configuration` holds its value from acceptance until the next accepted request, including after a failure.
- Requests while busy are not accepted (`req_ready` is low); the requester holds `req_valid`.
- A loss of lock after SUCCESS is not monitored by this block.

## Timing
- Reset values: `mgmt_clk_configuration` 3'h0, `mgmt_clk_reconfig` 0, `busy` 0, `done` 0, `error` 0, `current_config` 3'h0, `retry_cnt` 0, state IDLE (`req_ready` 1).
- Acceptance at edge N: `busy` and `mgmt_clk_configuration` update at N, `mgmt_clk_reconfig` is high for the cycle after N+1.
- Lock path latency is a 2-flop synchronizer plus `LOCK_STABLE` cycles, so the minimum from the first lock-high sample to `done` is 2+`LOCK_STABLE`+1 cycles.
- Counter width is `$clog2(max(DONE_TIMEOUT,LOCK_TIMEOUT)+1)`; counters saturate and never wrap.
- Reset asserted mid-operation aborts immediately to reset values; no reconfig pulse is issued afterwards.

## Configuration
- `PLL_RECONFIG_CTRL_RETRY_EN`
  - Defined: FAIL re-enters ISSUE up to `MAX_RETRY` times, and `retry_cnt` counts the retries.
  - Undefined: the first failure is final, and `retry_cnt` is tied to 0.

## Structure
- `ltpi_pkg` holds `pll_reconfig_state_t` (enum of the six states) and the `PLL_CFG_W = 3` width constant.
- One sub-module, `pll_lock_filter`: the 2-flop synchronizer plus the `LOCK_STABLE` consecutive-high qualifier. Its output is `lock_ok`; it clears its counter on a `clear` input pulsed in ISSUE.

## Test plan
- Reset release, then `req_config`=3'h5 with done returned after 10 cycles and lock stable → one reconfig pulse, `done` pulse, `current_config`=5, `error`=0.
- `mgmt_clk_configuration_done` never asserted, retry enabled → 3 reconfig pulses spaced about 1025 cycles apart, then `done`+`error`=1, `retry_cnt`=2, `current_config` unchanged.
- Lock toggles low every 10 cycles (less than `LOCK_STABLE`) → lock timeout, then `error`=1. The same test with retry disabled → exactly one reconfig pulse.
- `req_valid` held high during a request with a new `req_config`=3'h2 → ignored until IDLE, then accepted as a second transaction.
- `reset_n` pulsed low during WAIT_LOCK → all outputs return to reset values, and no further reconfig pulse occurs.
- Done and the DONE_TIMEOUT expiry on the same cycle → proceed to WAIT_LOCK with no failure.
